imem_arbiter: RTL and testbench

Single-port arbiter and sequencer for the pipelined CPU's byte-addressed, big-endian instruction memory. It shares one synchronous memory port between the fetch stage and the program loader/debug port, and checks alignment and range on every request. It routes the one-cycle-latency read data back to the correct requester. It sits between the IF stage, the loader and the instruction memory array.

---
 rtl/imem_arbiter.sv | 121 ++++++++++++
 tb/tb_imem_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// Single-port instruction-memory arbiter: shares one synchronous memory port between
// the fetch stage and the loader, faults bad requests and routes 1-cycle read data back.
module imem_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    // fetch side
    input  logic              f_req,
    input  logic [31:0]       f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [31:0]       f_rdata,
    output logic              f_fault,
    // loader / debug side
    input  logic              l_req,
    input  logic              l_we,
    input  logic [31:0]       l_addr,
    input  logic [7:0]        l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [31:0]       l_rdata,
    output logic              l_fault,
    // memory port
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [7:0]        m_wdata,
    input  logic [31:0]       m_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LOAD  = 2'd2
    } owner_t;

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    owner_t      r_owner;
    logic        r_resp_fault;
    logic        r_resp_write;
    logic [3:0]  r_wait_cnt;

    owner_t      w_owner_nxt;
    logic        w_resp_fault_nxt;
    logic        w_resp_write_nxt;
    logic [3:0]  w_wait_nxt;

    logic        w_l_win;
    logic        w_f_win;
    logic        w_any_gnt;
    logic [31:0] w_sel_addr;
    logic        w_sel_read;
    logic        w_range_flt;
    logic        w_align_flt;
    logic        w_fault;
    logic        w_resp_read_ok;

    // State register: response owner/qualifiers and fetch starvation counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_owner      <= OWN_NONE;
            r_resp_fault <= 1'b0;
            r_resp_write <= 1'b0;
            r_wait_cnt   <= 4'd0;
        end else begin
            r_owner      <= w_owner_nxt;
            r_resp_fault <= w_resp_fault_nxt;
            r_resp_write <= w_resp_write_nxt;
            r_wait_cnt   <= w_wait_nxt;
        end
    end

    // Next-state: arbitration, fault classification and response bookkeeping.
    always_comb begin
        w_l_win     = l_req && !(f_req && (r_wait_cnt == WAIT_MAX));
        w_f_win     = f_req && !w_l_win;
        w_any_gnt   = rst_n && (w_l_win || w_f_win);
        w_sel_addr  = w_l_win ? l_addr : f_addr;
        w_sel_read  = w_f_win || !l_we;
        // Byte writes may land on any offset; only word reads need alignment.
        w_range_flt = (w_sel_addr >> ADDR_W) != 32'd0;
        w_align_flt = w_sel_read && (w_sel_addr[1:0] != 2'b00);
        w_fault     = w_range_flt || w_align_flt;

        w_owner_nxt      = OWN_NONE;
        w_resp_fault_nxt = 1'b0;
        w_resp_write_nxt = 1'b0;
        if (w_any_gnt) begin
            w_owner_nxt      = w_l_win ? OWN_LOAD : OWN_FETCH;
            w_resp_fault_nxt = w_fault;
            w_resp_write_nxt = w_l_win && l_we;
        end

        w_wait_nxt = 4'd0;
        if (f_req && !(rst_n && w_f_win)) begin
            w_wait_nxt = (r_wait_cnt >= WAIT_MAX) ? WAIT_MAX : r_wait_cnt + 4'd1;
        end
    end

    // Outputs: grants and memory strobes are combinational; responses come from registers.
    always_comb begin
        f_gnt   = rst_n && w_f_win;
        l_gnt   = rst_n && w_l_win;
        m_en    = w_any_gnt && !w_fault;
        m_we    = m_en && w_l_win && l_we;
        m_addr  = m_en ? w_sel_addr[ADDR_W-1:0] : '0;
        m_wdata = m_en ? l_wdata : 8'd0;

        w_resp_read_ok = !r_resp_fault && !r_resp_write;
        f_rvalid = rst_n && (r_owner == OWN_FETCH);
        f_fault  = f_rvalid && r_resp_fault;
        f_rdata  = (f_rvalid && w_resp_read_ok) ? m_rdata : 32'd0;
        l_rvalid = rst_n && (r_owner == OWN_LOAD);
        l_fault  = l_rvalid && r_resp_fault;
        l_rdata  = (l_rvalid && w_resp_read_ok) ? m_rdata : 32'd0;
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Randomized scoreboard bench for imem_arbiter: a byte-array reference model predicts
// grants, memory strobes and responses; a monitor pops expected responses as they appear.
module tb_imem_arbiter;
  localparam int ADDR_W   = 10;
  localparam int MAX_WAIT = 4;
  localparam int MEM_SZ   = 1 << ADDR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic              f_req, f_gnt, f_rvalid, f_fault;
  logic [31:0]       f_addr, f_rdata;
  logic              l_req, l_we, l_gnt, l_rvalid, l_fault;
  logic [31:0]       l_addr, l_rdata;
  logic [7:0]        l_wdata;
  logic              m_en, m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [7:0]        m_wdata;
  logic [31:0]       m_rdata;

  imem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_rdata(f_rdata), .f_fault(f_fault),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt),
    .l_rvalid(l_rvalid), .l_rdata(l_rdata), .l_fault(l_fault),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  // Physical memory attached to the DUT port (big-endian words, 1-cycle read latency).
  logic [7:0] mem [MEM_SZ];
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr] <= m_wdata;
      else m_rdata <= {mem[m_addr], mem[m_addr + 10'd1], mem[m_addr + 10'd2], mem[m_addr + 10'd3]};
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int n_pass = 0;
  int n_total = 0;
  // entry = {due_cycle[31:0], fault, rdata[31:0]}
  logic [64:0] exp_f_q[$];
  logic [64:0] exp_l_q[$];

  logic [7:0] ref_mem [MEM_SZ];
  int         m_wait;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int b;
    b = int'(a[ADDR_W-1:0]);
    return {ref_mem[b], ref_mem[b+1], ref_mem[b+2], ref_mem[b+3]};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [64:0] e;
    if (f_rvalid) begin
      if (exp_f_q.size() == 0) chk("f_rvalid_unexpected", 32'(f_rvalid), 32'd0);
      else begin
        e = exp_f_q.pop_front();
        chk("f_resp_cycle", cyc, e[64:33]);
        chk("f_fault", 32'(f_fault), 32'(e[32]));
        chk("f_rdata", f_rdata, e[31:0]);
      end
    end else begin
      chk("f_idle_fault", 32'(f_fault), 32'd0);
      chk("f_idle_rdata", f_rdata, 32'd0);
      if (exp_f_q.size() != 0 && int'(exp_f_q[0][64:33]) <= cyc) begin
        chk("f_rvalid_missing", 32'(f_rvalid), 32'd1);
        void'(exp_f_q.pop_front());
      end
    end
    if (l_rvalid) begin
      if (exp_l_q.size() == 0) chk("l_rvalid_unexpected", 32'(l_rvalid), 32'd0);
      else begin
        e = exp_l_q.pop_front();
        chk("l_resp_cycle", cyc, e[64:33]);
        chk("l_fault", 32'(l_fault), 32'(e[32]));
        chk("l_rdata", l_rdata, e[31:0]);
      end
    end else begin
      chk("l_idle_fault", 32'(l_fault), 32'd0);
      chk("l_idle_rdata", l_rdata, 32'd0);
      if (exp_l_q.size() != 0 && int'(exp_l_q[0][64:33]) <= cyc) begin
        chk("l_rvalid_missing", 32'(l_rvalid), 32'd1);
        void'(exp_l_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  // One cycle: inputs are already applied; check the combinational side at negedge,
  // record the expected response, advance the model, return at posedge+1.
  task automatic step(output logic fg, output logic lg, output logic dut_fg);
    logic        ef, el, is_rd, flt, emen, ewe;
    logic [31:0] a, data;
    @(negedge clk);
    el = rst_n && l_req && !(f_req && m_wait == MAX_WAIT);
    ef = rst_n && f_req && !el;
    chk("f_gnt", 32'(f_gnt), 32'(ef));
    chk("l_gnt", 32'(l_gnt), 32'(el));
    a     = el ? l_addr : f_addr;
    is_rd = ef || !l_we;
    flt   = (a >= 32'(MEM_SZ)) || (is_rd && (a % 4 != 0));
    emen  = (el || ef) && !flt;
    ewe   = emen && el && l_we;
    chk("m_en", 32'(m_en), 32'(emen));
    chk("m_we", 32'(m_we), 32'(ewe));
    chk("m_addr", 32'(m_addr), emen ? a : 32'd0);
    chk("m_wdata", 32'(m_wdata), emen ? 32'(l_wdata) : 32'd0);
    if (el || ef) begin
      data = (flt || (el && l_we)) ? 32'd0 : ref_word(a);
      if (el) exp_l_q.push_back({32'(cyc + 1), flt, data});
      else    exp_f_q.push_back({32'(cyc + 1), flt, data});
      if (ewe) ref_mem[int'(a)] = l_wdata;
    end
    if (!rst_n) m_wait = 0;
    else if (f_req && !ef) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
    else m_wait = 0;
    fg = ef;
    lg = el;
    dut_fg = f_gnt;
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] a);
    logic fg, lg, dfg;
    f_req = 1'b1; f_addr = a;
    step(fg, lg, dfg);
    f_req = 1'b0;
  endtask

  task automatic do_load(input logic we, input logic [31:0] a, input logic [7:0] d);
    logic fg, lg, dfg;
    l_req = 1'b1; l_we = we; l_addr = a; l_wdata = d;
    step(fg, lg, dfg);
    l_req = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr(input logic is_write);
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return $urandom;
    if (r == 1) return 32'(MEM_SZ + $urandom_range(0, MEM_SZ - 1));
    if (r <= 3 || is_write) return 32'($urandom_range(0, MEM_SZ - 1));
    return 32'($urandom_range(0, MEM_SZ / 4 - 1) * 4);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic fg, lg, dfg;
    logic f_pend, l_pend;
    rst_n = 1'b0;
    f_req = 1'b0; f_addr = 32'd0;
    l_req = 1'b0; l_we = 1'b0; l_addr = 32'd0; l_wdata = 8'd0;
    m_wait = 0;
    for (int i = 0; i < MEM_SZ; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[32'h100] = 8'h12; mem[32'h101] = 8'h34; mem[32'h102] = 8'h56; mem[32'h103] = 8'h78;
    for (int i = 0; i < 4; i++) ref_mem[32'h100 + i] = mem[32'h100 + i];

    // Requests during reset must not be granted.
    @(posedge clk); #1;
    f_req = 1'b1; l_req = 1'b1; l_addr = 32'h10;
    repeat (3) step(fg, lg, dfg);
    f_req = 1'b0; l_req = 1'b0;
    rst_n = 1'b1;
    step(fg, lg, dfg);

    // Big-endian word fetch.
    do_fetch(32'h100);
    chk("tp_fetch_word", f_rdata, 32'h12345678);
    chk("tp_fetch_valid", 32'(f_rvalid), 32'd1);

    // Byte write to the last byte, then read it back through fetch.
    do_load(1'b1, 32'h3FF, 8'hA5);
    chk("tp_write_ack", 32'(l_rvalid), 32'd1);
    chk("tp_write_rdata", l_rdata, 32'd0);
    do_fetch(32'h3FC);
    chk("tp_readback_byte", 32'(f_rdata[7:0]), 32'hA5);

    // Misaligned fetch and out-of-range loader read.
    do_fetch(32'h102);
    chk("tp_misalign_fault", 32'(f_fault), 32'd1);
    chk("tp_misalign_rdata", f_rdata, 32'd0);
    do_load(1'b0, 32'h400, 8'd0);
    chk("tp_range_fault", 32'(l_fault), 32'd1);
    step(fg, lg, dfg);

    // Continuous contention: four loader grants then one fetch grant, repeating.
    f_req = 1'b1; f_addr = 32'h40; l_req = 1'b1; l_we = 1'b0; l_addr = 32'h80;
    for (int i = 0; i < 15; i++) begin
      step(fg, lg, dfg);
      chk("tp_starve_pattern", 32'(dfg), 32'((i % 5) == 4));
    end
    f_req = 1'b0; l_req = 1'b0;
    step(fg, lg, dfg);

    // Back-to-back fetches.
    f_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      f_addr = 32'(i * 4);
      step(fg, lg, dfg);
    end
    f_req = 1'b0;
    step(fg, lg, dfg);

    // Reset during the response cycle of a granted read drops the response.
    f_req = 1'b1; f_addr = 32'h10;
    step(fg, lg, dfg);
    rst_n = 1'b0;
    exp_f_q.delete();
    exp_l_q.delete();
    #1;
    chk("rst_f_rvalid", 32'(f_rvalid), 32'd0);
    chk("rst_m_en", 32'(m_en), 32'd0);
    step(fg, lg, dfg);
    rst_n = 1'b1; f_addr = 32'h20;
    step(fg, lg, dfg);
    f_req = 1'b0;
    step(fg, lg, dfg);

    // Randomized traffic; each requester holds its request until granted.
    f_pend = 1'b0; l_pend = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!f_pend && $urandom_range(0, 9) < 7) begin
        f_req = 1'b1; f_addr = rand_addr(1'b0); f_pend = 1'b1;
      end
      if (!l_pend && $urandom_range(0, 9) < 5) begin
        l_req = 1'b1; l_we = 1'($urandom_range(0, 1));
        l_addr = rand_addr(l_we); l_wdata = 8'($urandom); l_pend = 1'b1;
      end
      step(fg, lg, dfg);
      if (fg) begin f_pend = 1'b0; f_req = 1'b0; end
      if (lg) begin l_pend = 1'b0; l_req = 1'b0; end
    end
    f_req = 1'b0; l_req = 1'b0;
    repeat (3) step(fg, lg, dfg);
    chk("f_queue_drained", 32'(exp_f_q.size()), 32'd0);
    chk("l_queue_drained", 32'(exp_l_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
